cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Synthesizable commit-trace capture unit for the single-cycle CPU top level. It records retired instructions (pc, inst, register-file write) into a parametrised circular buffer, using a pc-match trigger, a stop count and a wrap/stop-on-full mode. Captured records drain through a valid/ready port, so the regfile/pc dumps previously produced by the simulation bench are available on hardware and in post-synthesis simulation.

## Interface
- DATA_W, 32, width of pc, inst and write data
- DEPTH, 16, buffer entries; power of two, ≥2
- CNT_W, 32, width of cycle stamp
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- arm  in  1  start capture session (sampled in IDLE only)
- mode_wrap  in  1  1: overwrite oldest when full; 0: drop new when full
- trig_en  in  1  1: wait for trig_pc before capturing
- trig_pc  in  DATA_W  trigger address
- stop_count  in  16  records to capture, 0 = unlimited
- commit_valid  in  1  one instruction retires this cycle
- commit_pc, commit_inst  in  DATA_W  retired pc / instruction
- commit_rf_we  in  1  retired instruction writes regfile
- commit_rf_waddr  in  5  destination register
- commit_rf_wdata  in  DATA_W  written value
- rd_valid  out  1  head record available
- rd_ready  in  1  consumer accepts head
- rd_pc, rd_inst, rd_rf_wdata  out  DATA_W  head record fields
- rd_rf_we  out  1, rd_rf_waddr  out  5  head record fields
- rd_cycle  out  CNT_W  cycle stamp of head record
- state  out  2  FSM state
- level  out  log2(DEPTH)+1  occupancy
- overflow  out  1  sticky: a record was dropped or overwritten
- captured  out  16  records accepted this session

## Operation
- States: IDLE(0), WAIT_TRIG(1), CAPTURE(2), DONE(3).
- IDLE & arm: clear buffer, level, captured, overflow, cycle counter; go WAIT_TRIG if trig_en else CAPTURE. arm ignored outside IDLE.
- Cycle counter: increments every cycle outside IDLE, starts at 0 the cycle after arm; saturates at all-ones.
- WAIT_TRIG: commit_valid & commit_pc==trig_pc → that commit is captured, go CAPTURE. Other commits ignored.
- CAPTURE: each commit_valid pushes one record {pc, inst, rf_we, rf_waddr, rf_wdata, cycle}; captured increments on each accepted push.
- stop_count≠0 & captured reaches stop_count → DONE same edge as final push.
- DONE: no pushes; when level==0 → IDLE.
- Full, mode_wrap=0: push dropped, captured unchanged, overflow←1.
- Full, mode_wrap=1: oldest overwritten, head advances, level stays DEPTH, captured increments, overflow←1.
- Pop on rd_valid & rd_ready, in any state. Push and pop same cycle: both occur, level unchanged; when full this is never an overwrite and overflow is not set.
- rd_valid = (level≠0). Head fields are first-word-fall-through and stable while rd_valid & !rd_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values: state=IDLE, level=0, captured=0, overflow=0, rd_valid=0, all rd_* fields 0, cycle=0.
- Reset mid-session discards all contents immediately (asynchronous).
- Push latency: commit at edge N gives rd_valid=1 after edge N (visible in cycle N+1).
- Pop: head advances on the accepting edge. The next record appears the following cycle with no bubble.
- State transitions are registered. The trigger commit and the entry into CAPTURE happen on the same edge.

## Structure
- Package cpu_trace_pkg: state encoding constants, record field widths, record packing helpers.
- Sub-module trace_fifo: DEPTH×record storage, pointers, level, full/empty, overwrite-on-full input. cpu_trace_buffer contains the FSM, trigger compare, counters and overflow flag.

## Test plan
- DEPTH=4, no trigger, stop_count=3, 5 commits pc=0,4,8,C,10 with rd_ready=0 → captured=3, level=3, state=DONE; drain gives pc 0,4,8, then state=IDLE.
- trig_en, trig_pc=0x10, commits pc=0..0x1C step 4 → first record pc=0x10, level=4.
- DEPTH=4, mode_wrap=0, 6 commits, no reads → pcs 0..0xC kept, overflow=1, captured=4.
- DEPTH=4, mode_wrap=1, 6 commits pc=0..0x14 → drain gives 0x8,0xC,0x10,0x14, overflow=1, captured=6.
- Full buffer, rd_ready=1 and commit same cycle → level stays 4, overflow=0, no record lost.
- Reset asserted mid-CAPTURE with level=2 → rd_valid=0, state=IDLE at once; arm afterwards restarts with cycle stamp 0.

Source files
------------

// File: rtl/cpu_trace_buffer_pkg.sv
// rtl/cpu_trace_buffer_pkg.sv - state encoding and record layout for the commit-trace buffer
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam int RF_ADDR_W = 5;
  localparam int STOP_W    = 16;

  // Record layout, msb first: pc, inst, rf_we, rf_waddr, rf_wdata, cycle
  function automatic int rec_width(input int data_w, input int cnt_w);
    return 3 * data_w + 1 + RF_ADDR_W + cnt_w;
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// rtl/cpu_trace_buffer_if.sv - commit input and record drain port of the trace buffer
interface cpu_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              commit_valid;
  logic [DATA_W-1:0] commit_pc;
  logic [DATA_W-1:0] commit_inst;
  logic              commit_rf_we;
  logic [4:0]        commit_rf_waddr;
  logic [DATA_W-1:0] commit_rf_wdata;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_inst;
  logic              rd_rf_we;
  logic [4:0]        rd_rf_waddr;
  logic [DATA_W-1:0] rd_rf_wdata;
  logic [CNT_W-1:0]  rd_cycle;

  modport master (
    output commit_valid, commit_pc, commit_inst, commit_rf_we, commit_rf_waddr, commit_rf_wdata,
    output rd_ready,
    input  rd_valid, rd_pc, rd_inst, rd_rf_we, rd_rf_waddr, rd_rf_wdata, rd_cycle
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst, commit_rf_we, commit_rf_waddr, commit_rf_wdata,
    input  rd_ready,
    output rd_valid, rd_pc, rd_inst, rd_rf_we, rd_rf_waddr, rd_rf_wdata, rd_cycle
  );
endinterface

// File: rtl/cpu_trace_buffer_fifo.sv
// rtl/cpu_trace_buffer_fifo.sv - first-word-fall-through circular record store with overwrite-on-full
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       wrap,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_write;
  logic             overwrite;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // A pop in the same cycle frees a slot, so a full push then never overwrites
  assign do_pop    = pop && !empty;
  assign do_write  = push && (!full || do_pop || wrap);
  assign overwrite = push && full && !do_pop && wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop || overwrite)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !do_pop && !overwrite)
        level <= level + 1'b1;
      else if (do_pop && !do_write)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !clr)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - commit-trace capture: trigger, stop count, cycle stamping, overflow flag
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      mode_wrap,
  input  logic                      trig_en,
  input  logic [DATA_W-1:0]         trig_pc,
  input  logic [STOP_W-1:0]         stop_count,
  cpu_trace_buffer_if.slave         bus,
  output logic [1:0]                state,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [STOP_W-1:0]         captured
);
  localparam int REC_W = rec_width(DATA_W, CNT_W);

  state_t            st;
  logic [CNT_W-1:0]  cycle;
  logic [REC_W-1:0]  wdata;
  logic [REC_W-1:0]  rdata;
  logic              full;
  logic              empty;
  logic              clr;
  logic              push_req;
  logic              do_pop;
  logic              accept;
  logic              ovf_evt;
  logic              stop_hit;
  logic [STOP_W-1:0] captured_inc;

  assign state = st;
  assign clr   = (st == ST_IDLE) && arm;

  assign push_req = bus.commit_valid &&
                    ((st == ST_CAPTURE) ||
                     ((st == ST_WAIT_TRIG) && (bus.commit_pc == trig_pc)));
  assign do_pop   = bus.rd_valid && bus.rd_ready;
  assign accept   = push_req && (!full || do_pop || mode_wrap);
  assign ovf_evt  = push_req && full && !do_pop;

  assign captured_inc = captured + 1'b1;
  assign stop_hit     = accept && (stop_count != '0) && (captured_inc == stop_count);

  assign wdata = {bus.commit_pc, bus.commit_inst, bus.commit_rf_we,
                  bus.commit_rf_waddr, bus.commit_rf_wdata, cycle};

  trace_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (push_req),
    .pop   (do_pop),
    .wrap  (mode_wrap),
    .wdata (wdata),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign bus.rd_valid = !empty;
  assign {bus.rd_pc, bus.rd_inst, bus.rd_rf_we, bus.rd_rf_waddr,
          bus.rd_rf_wdata, bus.rd_cycle} = rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= ST_IDLE;
      captured <= '0;
      overflow <= 1'b0;
      cycle    <= '0;
    end else if (st == ST_IDLE) begin
      if (arm) begin
        captured <= '0;
        overflow <= 1'b0;
        cycle    <= '0;
        st       <= trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
      end
    end else begin
      if (cycle != '1)
        cycle <= cycle + 1'b1;
      if (accept)
        captured <= captured_inc;
      if (ovf_evt)
        overflow <= 1'b1;
      case (st)
        // The trigger commit itself is the first record of the session
        ST_WAIT_TRIG: if (push_req) st <= stop_hit ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE:   if (stop_hit) st <= ST_DONE;
        ST_DONE:      if (empty)    st <= ST_IDLE;
        default:      st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - directed self-checking bench for cpu_trace_buffer with DEPTH=4
module tb_cpu_trace_buffer;
  logic        clk;
  logic        reset;
  logic        arm;
  logic        mode_wrap;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic [15:0] stop_count;
  logic [1:0]  state;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] captured;

  int tests;
  int fails;

  cpu_trace_buffer_if #(.DATA_W(32), .CNT_W(32)) bus ();

  cpu_trace_buffer #(
    .DATA_W (32),
    .DEPTH  (4),
    .CNT_W  (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .mode_wrap  (mode_wrap),
    .trig_en    (trig_en),
    .trig_pc    (trig_pc),
    .stop_count (stop_count),
    .bus        (bus.slave),
    .state      (state),
    .level      (level),
    .overflow   (overflow),
    .captured   (captured)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0;
    arm = 1'b0;
    mode_wrap = 1'b0;
    trig_en = 1'b0;
    trig_pc = '0;
    stop_count = '0;
    bus.commit_valid = 1'b0;
    bus.commit_pc = '0;
    bus.commit_inst = '0;
    bus.commit_rf_we = 1'b0;
    bus.commit_rf_waddr = '0;
    bus.commit_rf_wdata = '0;
    bus.rd_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic do_arm(input logic wrap, input logic ten, input logic [31:0] tpc, input logic [15:0] stop);
    mode_wrap = wrap;
    trig_en = ten;
    trig_pc = tpc;
    stop_count = stop;
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] pc);
    bus.commit_valid = 1'b1;
    bus.commit_pc = pc;
    bus.commit_inst = pc ^ 32'hA5A5_0000;
    bus.commit_rf_we = pc[2];
    bus.commit_rf_waddr = pc[6:2];
    bus.commit_rf_wdata = pc + 32'h1000;
    @(posedge clk);
    #1;
    bus.commit_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (state !== 2'd0 || level !== 3'd0 || captured !== 16'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: state=%0d level=%0d captured=%0d overflow=%0b, want 0 0 0 0", state, level, captured, overflow);
    end
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.rd_pc !== 32'd0 || bus.rd_inst !== 32'd0 || bus.rd_cycle !== 32'd0 ||
        bus.rd_rf_we !== 1'b0 || bus.rd_rf_waddr !== 5'd0 || bus.rd_rf_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_rd: rd_valid=%0b rd_pc=%h rd_cycle=%0d, want all zero", bus.rd_valid, bus.rd_pc, bus.rd_cycle);
    end
  endtask

  task automatic test_stop_count();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    do_reset();
    do_arm(1'b0, 1'b0, 32'h0, 16'd3);
    tests++;
    if (state !== 2'd2) begin
      fails++;
      $display("FAIL stop_arm_state: got %0d want 2", state);
    end
    for (int i = 0; i < 5; i++) do_commit(32'(i * 4));
    tests++;
    if (captured !== 16'd3 || level !== 3'd3 || state !== 2'd3) begin
      fails++;
      $display("FAIL stop_done: captured=%0d level=%0d state=%0d, want 3 3 3", captured, level, state);
    end
    tests++;
    if (bus.rd_cycle !== 32'd0 || bus.rd_inst !== 32'hA5A5_0000 || bus.rd_rf_we !== 1'b0 ||
        bus.rd_rf_waddr !== 5'd0 || bus.rd_rf_wdata !== 32'h1000) begin
      fails++;
      $display("FAIL stop_head_fields: cycle=%0d inst=%h we=%0b waddr=%0d wdata=%h, want 0 a5a50000 0 0 1000",
               bus.rd_cycle, bus.rd_inst, bus.rd_rf_we, bus.rd_rf_waddr, bus.rd_rf_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp_pc[i] || bus.rd_cycle !== 32'(i)) begin
        fails++;
        $display("FAIL stop_drain_%0d: valid=%0b pc=%h cycle=%0d, want 1 %h %0d", i, bus.rd_valid, bus.rd_pc, bus.rd_cycle, exp_pc[i], i);
      end
      bus.rd_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rd_ready = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (state !== 2'd0 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL stop_idle: state=%0d rd_valid=%0b, want 0 0", state, bus.rd_valid);
    end
  endtask

  task automatic test_trigger();
    do_reset();
    do_arm(1'b0, 1'b1, 32'h10, 16'd0);
    tests++;
    if (state !== 2'd1) begin
      fails++;
      $display("FAIL trig_wait_state: got %0d want 1", state);
    end
    for (int i = 0; i < 4; i++) do_commit(32'(i * 4));
    tests++;
    if (level !== 3'd0 || state !== 2'd1) begin
      fails++;
      $display("FAIL trig_before: level=%0d state=%0d, want 0 1", level, state);
    end
    do_commit(32'h10);
    tests++;
    if (state !== 2'd2 || level !== 3'd1) begin
      fails++;
      $display("FAIL trig_hit: state=%0d level=%0d, want 2 1", state, level);
    end
    for (int i = 5; i < 8; i++) do_commit(32'(i * 4));
    tests++;
    if (bus.rd_pc !== 32'h10 || level !== 3'd4 || captured !== 16'd4 || overflow !== 1'b0 || bus.rd_cycle !== 32'd4) begin
      fails++;
      $display("FAIL trig_result: pc=%h level=%0d captured=%0d ovf=%0b cycle=%0d, want 10 4 4 0 4",
               bus.rd_pc, level, captured, overflow, bus.rd_cycle);
    end
  endtask

  task automatic test_full_drop();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    do_arm(1'b0, 1'b0, 32'h0, 16'd0);
    for (int i = 0; i < 6; i++) do_commit(32'(i * 4));
    tests++;
    if (level !== 3'd4 || captured !== 16'd4 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL drop_status: level=%0d captured=%0d ovf=%0b, want 4 4 1", level, captured, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp_pc[i]) begin
        fails++;
        $display("FAIL drop_drain_%0d: valid=%0b pc=%h, want 1 %h", i, bus.rd_valid, bus.rd_pc, exp_pc[i]);
      end
      bus.rd_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rd_ready = 1'b0;
    tests++;
    if (bus.rd_valid !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL drop_empty: valid=%0b level=%0d, want 0 0", bus.rd_valid, level);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h8, 32'hC, 32'h10, 32'h14};
    do_reset();
    do_arm(1'b1, 1'b0, 32'h0, 16'd0);
    for (int i = 0; i < 6; i++) do_commit(32'(i * 4));
    tests++;
    if (level !== 3'd4 || captured !== 16'd6 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL wrap_status: level=%0d captured=%0d ovf=%0b, want 4 6 1", level, captured, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp_pc[i] || bus.rd_cycle !== 32'(i + 2)) begin
        fails++;
        $display("FAIL wrap_drain_%0d: valid=%0b pc=%h cycle=%0d, want 1 %h %0d", i, bus.rd_valid, bus.rd_pc, bus.rd_cycle, exp_pc[i], i + 2);
      end
      bus.rd_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    do_arm(1'b0, 1'b0, 32'h0, 16'd0);
    for (int i = 0; i < 4; i++) do_commit(32'(i * 4));
    bus.rd_ready = 1'b1;
    do_commit(32'h10);
    bus.rd_ready = 1'b0;
    tests++;
    if (level !== 3'd4 || overflow !== 1'b0 || captured !== 16'd5) begin
      fails++;
      $display("FAIL b2b_status: level=%0d ovf=%0b captured=%0d, want 4 0 5", level, overflow, captured);
    end
    #3;
    tests++;
    if (bus.rd_pc !== 32'h4) begin
      fails++;
      $display("FAIL b2b_stall_hold: pc=%h want 4", bus.rd_pc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp_pc[i]) begin
        fails++;
        $display("FAIL b2b_drain_%0d: valid=%0b pc=%h, want 1 %h", i, bus.rd_valid, bus.rd_pc, exp_pc[i]);
      end
      bus.rd_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_arm(1'b0, 1'b0, 32'h0, 16'd0);
    do_commit(32'h20);
    do_commit(32'h24);
    do_commit(32'h28);
    tests++;
    if (level !== 3'd3 || state !== 2'd2) begin
      fails++;
      $display("FAIL mid_pre: level=%0d state=%0d, want 3 2", level, state);
    end
    bus.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_ready = 1'b0;
    tests++;
    if (level !== 3'd2) begin
      fails++;
      $display("FAIL mid_level: level=%0d want 2", level);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.rd_valid !== 1'b0 || state !== 2'd0 || level !== 3'd0 || bus.rd_pc !== 32'd0) begin
      fails++;
      $display("FAIL mid_async: valid=%0b state=%0d level=%0d pc=%h, want 0 0 0 0", bus.rd_valid, state, level, bus.rd_pc);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    do_arm(1'b0, 1'b0, 32'h0, 16'd0);
    do_commit(32'h40);
    tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'h40 || bus.rd_cycle !== 32'd0 || captured !== 16'd1) begin
      fails++;
      $display("FAIL mid_restart: valid=%0b pc=%h cycle=%0d captured=%0d, want 1 40 0 1",
               bus.rd_valid, bus.rd_pc, bus.rd_cycle, captured);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_stop_count();
    test_trigger();
    test_full_drop();
    test_full_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
